// File: rtl/vram_write_arbiter.sv
// Write-port arbiter for the 8x8 LED display RAM: fill engine > host > pen.
// Optional `VRAM_ARB_RR_EN: host and pen share round-robin priority below the fill engine.
module vram_write_arbiter #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic [ROWS-1:0]   host_row,
    input  logic [COLS-1:0]   host_col,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ack,
    input  logic              pen_req,
    input  logic [ROWS-1:0]   pen_row,
    input  logic [COLS-1:0]   pen_col,
    input  logic [DATA_W-1:0] pen_data,
    output logic              pen_ack,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_data,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              addr_err,
    output logic              ram_we,
    output logic [ROWS-1:0]   ram_row,
    output logic [COLS-1:0]   ram_col,
    output logic [DATA_W-1:0] ram_data
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t              state;
    logic [5:0]          cnt;
    logic [DATA_W-1:0]   fill_data;
    logic                pend;
    logic [DATA_W-1:0]   pend_data;

    logic                host_ok, pen_ok, start, arb_open, pick_pen;
    logic                grant_host, grant_pen, addr_ok;
    logic [ROWS-1:0]     sel_row;
    logic [COLS-1:0]     sel_col;
    logic [DATA_W-1:0]   sel_data;

`ifdef VRAM_ARB_RR_EN
    logic                rr_pen;
`endif

    // A requester whose ack is high this cycle is still holding req; mask it.
    assign host_ok  = host_req && !host_ack;
    assign pen_ok   = pen_req && !pen_ack;
    assign start    = (state == IDLE) && (clr_start || pend);
    assign arb_open = ((state == IDLE) && !start) || (state == DONE);

`ifdef VRAM_ARB_RR_EN
    assign pick_pen = pen_ok && (!host_ok || rr_pen);
`else
    assign pick_pen = pen_ok && !host_ok;
`endif

    assign grant_host = arb_open && host_ok && !pick_pen;
    assign grant_pen  = arb_open && pick_pen;

    assign sel_row  = grant_host ? host_row  : pen_row;
    assign sel_col  = grant_host ? host_col  : pen_col;
    assign sel_data = grant_host ? host_data : pen_data;
    assign addr_ok  = $onehot(sel_row) && $onehot(sel_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fill_data <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
            host_ack  <= 1'b0;
            pen_ack   <= 1'b0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
            addr_err  <= 1'b0;
            ram_we    <= 1'b0;
            ram_row   <= '0;
            ram_col   <= '0;
            ram_data  <= '0;
`ifdef VRAM_ARB_RR_EN
            rr_pen    <= 1'b0;
`endif
        end else begin
            host_ack <= grant_host;
            pen_ack  <= grant_pen;
            addr_err <= (grant_host || grant_pen) && !addr_ok;
            ram_we   <= 1'b0;
            clr_done <= 1'b0;

            // Bad addresses are still acked but leave the RAM outputs untouched.
            if ((grant_host || grant_pen) && addr_ok) begin
                ram_we   <= 1'b1;
                ram_row  <= sel_row;
                ram_col  <= sel_col;
                ram_data <= sel_data;
            end

`ifdef VRAM_ARB_RR_EN
            if (grant_host)     rr_pen <= 1'b1;
            else if (grant_pen) rr_pen <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (start) begin
                        fill_data <= pend ? pend_data : clr_data;
                        cnt       <= '0;
                        clr_busy  <= 1'b1;
                        pend      <= 1'b0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    ram_we   <= 1'b1;
                    ram_row  <= ROWS'(1) << cnt[5:3];
                    ram_col  <= COLS'(1) << cnt[2:0];
                    ram_data <= fill_data;
                    cnt      <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // A start seen here is deferred to the next IDLE cycle.
                    if (clr_start) begin
                        pend      <= 1'b1;
                        pend_data <= clr_data;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed self-checking bench for vram_write_arbiter (default fixed-priority build).
module tb_vram_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_req = 1'b0, pen_req = 1'b0, clr_start = 1'b0;
    logic [7:0] host_row = '0, host_col = '0, pen_row = '0, pen_col = '0;
    logic [3:0] host_data = '0, pen_data = '0, clr_data = '0;
    logic       host_ack, pen_ack, clr_busy, clr_done, addr_err, ram_we;
    logic [7:0] ram_row, ram_col;
    logic [3:0] ram_data;

    int n_cmp = 0;
    int n_err = 0;

    vram_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_row(host_row), .host_col(host_col),
        .host_data(host_data), .host_ack(host_ack),
        .pen_req(pen_req), .pen_row(pen_row), .pen_col(pen_col),
        .pen_data(pen_data), .pen_ack(pen_ack),
        .clr_start(clr_start), .clr_data(clr_data),
        .clr_busy(clr_busy), .clr_done(clr_done), .addr_err(addr_err),
        .ram_we(ram_we), .ram_row(ram_row), .ram_col(ram_col), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observes a fill pass for a fixed number of cycles; clr_start pulsed at cycle poke.
    task automatic run_pass(input int cycles, input int poke, input logic [3:0] fdat,
                            output int nwe, output int nbad, output int nbusy,
                            output int ndone, output int first_we, output int last_we,
                            output int last_busy, output int done_cyc);
        logic [7:0] er, ec;
        nwe = 0; nbad = 0; nbusy = 0; ndone = 0;
        first_we = -1; last_we = -1; last_busy = -1; done_cyc = -1;
        for (int c = 0; c < cycles; c++) begin
            clr_start = (c == poke);
            tick();
            if (ram_we) begin
                er = 8'h01 << (nwe / 8);
                ec = 8'h01 << (nwe % 8);
                if (ram_row !== er || ram_col !== ec || ram_data !== fdat) nbad++;
                if (first_we < 0) first_we = c;
                last_we = c;
                nwe++;
            end
            if (clr_busy) begin nbusy++; last_busy = c; end
            if (clr_done) begin ndone++; done_cyc = c; end
        end
        clr_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({host_ack, pen_ack, clr_busy, clr_done, addr_err, ram_we} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctl got %b want 000000",
                {host_ack, pen_ack, clr_busy, clr_done, addr_err, ram_we});
        end
        n_cmp++;
        if ({ram_row, ram_col, ram_data} !== 20'h0) begin
            n_err++; $display("FAIL reset_ram got %h want 00000", {ram_row, ram_col, ram_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_host_write();
        host_req = 1'b1; host_row = 8'h04; host_col = 8'h10; host_data = 4'hA;
        tick();
        n_cmp++;
        if ({host_ack, ram_we, addr_err} !== 3'b110) begin
            n_err++; $display("FAIL host_ack got ack/we/err=%b want 110", {host_ack, ram_we, addr_err});
        end
        n_cmp++;
        if ({ram_row, ram_col, ram_data} !== {8'h04, 8'h10, 4'hA}) begin
            n_err++; $display("FAIL host_ram got %h want 0410a", {ram_row, ram_col, ram_data});
        end
        tick();  // req still high during ack cycle: must be masked
        n_cmp++;
        if ({host_ack, ram_we} !== 2'b00) begin
            n_err++; $display("FAIL host_single_pulse got ack/we=%b want 00", {host_ack, ram_we});
        end
        n_cmp++;
        if (ram_row !== 8'h04) begin
            n_err++; $display("FAIL host_hold got row %h want 04", ram_row);
        end
        host_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        host_req = 1'b1; host_row = 8'h01; host_col = 8'h01; host_data = 4'h3;
        pen_req  = 1'b1; pen_row  = 8'h02; pen_col  = 8'h40; pen_data  = 4'h6;
        tick();
        n_cmp++;
        if ({host_ack, pen_ack, ram_row, ram_data} !== {2'b10, 8'h01, 4'h3}) begin
            n_err++; $display("FAIL b2b_first got h/p=%b row %h data %h want 10 01 3",
                {host_ack, pen_ack}, ram_row, ram_data);
        end
        tick();
        host_req = 1'b0;
        n_cmp++;
        if ({host_ack, pen_ack, ram_row, ram_col, ram_data} !== {2'b01, 8'h02, 8'h40, 4'h6}) begin
            n_err++; $display("FAIL b2b_second got h/p=%b ram %h want 01 02406",
                {host_ack, pen_ack}, {ram_row, ram_col, ram_data});
        end
        tick();
        pen_req = 1'b0;
        n_cmp++;
        if ({host_ack, pen_ack, ram_we} !== 3'b000) begin
            n_err++; $display("FAIL b2b_no_regrant got h/p/we=%b want 000", {host_ack, pen_ack, ram_we});
        end
        tick();
    endtask

    task automatic test_fill();
        int nwe, nbad, nbusy, ndone, fw, lw, lb, dc;
        clr_data = 4'hC; clr_start = 1'b1;
        tick();
        clr_data = 4'h3;  // must not affect the pass
        n_cmp++;
        if ({clr_busy, ram_we} !== 2'b10) begin
            n_err++; $display("FAIL fill_start got busy/we=%b want 10", {clr_busy, ram_we});
        end
        run_pass(72, 5, 4'hC, nwe, nbad, nbusy, ndone, fw, lw, lb, dc);
        n_cmp++;
        if (nwe !== 64 || lw - fw + 1 !== 64) begin
            n_err++; $display("FAIL fill_writes got %0d writes span %0d want 64/64", nwe, lw - fw + 1);
        end
        n_cmp++;
        if (nbad !== 0) begin
            n_err++; $display("FAIL fill_order got %0d bad writes want 0", nbad);
        end
        n_cmp++;
        if (nbusy + 1 !== 64) begin
            n_err++; $display("FAIL fill_busy got %0d cycles want 64", nbusy + 1);
        end
        n_cmp++;
        if (ndone !== 1 || dc !== lb + 1) begin
            n_err++; $display("FAIL fill_done got %0d pulses at %0d want 1 at %0d", ndone, dc, lb + 1);
        end
    endtask

    task automatic test_pen_during_fill();
        int dc = -1, ac = -1, nack = 0;
        logic [19:0] seen = '0;
        clr_data = 4'h5; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (c == 10) begin
                pen_req = 1'b1; pen_row = 8'h20; pen_col = 8'h02; pen_data = 4'h7;
            end
            tick();
            if (clr_done) dc = c;
            if (pen_ack) begin
                nack++; ac = c; seen = {ram_row, ram_col, ram_data};
                pen_req = 1'b0;
            end
        end
        n_cmp++;
        if (nack !== 1 || ac !== dc + 1) begin
            n_err++; $display("FAIL pen_stall got %0d acks at %0d want 1 at %0d", nack, ac, dc + 1);
        end
        n_cmp++;
        if (seen !== {8'h20, 8'h02, 4'h7}) begin
            n_err++; $display("FAIL pen_data got %h want 20027", seen);
        end
    endtask

    task automatic test_fill_vs_host();
        int dc = -1, ac = -1;
        logic [3:0] seen = '0;
        clr_data = 4'h1; clr_start = 1'b1;
        host_req = 1'b1; host_row = 8'h80; host_col = 8'h80; host_data = 4'h9;
        tick();
        clr_start = 1'b0;
        n_cmp++;
        if ({host_ack, clr_busy} !== 2'b01) begin
            n_err++; $display("FAIL fill_wins got ack/busy=%b want 01", {host_ack, clr_busy});
        end
        for (int c = 0; c < 80; c++) begin
            tick();
            if (clr_done) dc = c;
            if (host_ack && ac < 0) begin ac = c; seen = ram_data; host_req = 1'b0; end
        end
        n_cmp++;
        if (ac !== dc + 1 || seen !== 4'h9) begin
            n_err++; $display("FAIL host_after_fill got ack at %0d data %h want %0d data 9", ac, seen, dc + 1);
        end
    endtask

    task automatic test_addr_err();
        logic [7:0] bad_rows [2];
        bad_rows[0] = 8'h03; bad_rows[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            pen_req = 1'b1; pen_row = bad_rows[i]; pen_col = 8'h01; pen_data = 4'hF;
            tick();
            pen_req = 1'b0;
            n_cmp++;
            if ({pen_ack, addr_err, ram_we} !== 3'b110) begin
                n_err++; $display("FAIL addr_err_%0d got ack/err/we=%b want 110", i, {pen_ack, addr_err, ram_we});
            end
            n_cmp++;
            if ({ram_row, ram_col, ram_data} !== {8'h80, 8'h80, 4'h9}) begin
                n_err++; $display("FAIL addr_hold_%0d got %h want 80809", i, {ram_row, ram_col, ram_data});
            end
            tick();
            n_cmp++;
            if (addr_err !== 1'b0) begin
                n_err++; $display("FAIL addr_err_pulse_%0d got %b want 0", i, addr_err);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int nwe, nbad, nbusy, ndone, fw, lw, lb, dc;
        clr_data = 4'h6; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        run_pass(20, -1, 4'h6, nwe, nbad, nbusy, ndone, fw, lw, lb, dc);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({host_ack, pen_ack, clr_busy, clr_done, addr_err, ram_we, ram_row, ram_col, ram_data} !== 26'h0) begin
            n_err++; $display("FAIL async_reset got busy %b we %b ram %h want all 0",
                clr_busy, ram_we, {ram_row, ram_col, ram_data});
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_err++; $display("FAIL abort_no_done got %0d want 0", ndone);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        clr_data = 4'hB; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        run_pass(70, -1, 4'hB, nwe, nbad, nbusy, ndone, fw, lw, lb, dc);
        n_cmp++;
        if (nwe !== 64 || nbad !== 0 || ndone !== 1) begin
            n_err++; $display("FAIL pass_after_reset got %0d writes %0d bad %0d done want 64/0/1", nwe, nbad, ndone);
        end
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_back_to_back();
        test_fill();
        test_pen_during_fill();
        test_fill_vs_host();
        test_addr_err();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
